// File: rtl/pdm_pkg.sv
// Shared definitions for the packet discard stage: MD field positions,
// configure-chain codes and counter addresses.
package pdm_pkg;

  localparam int MD_W  = 256;
  localparam int PHV_W = 1024;
  localparam int CFG_W = 134;

  localparam int MID_HI      = 87;
  localparam int MID_LO      = 80;
  localparam int PROT_HI     = 79;
  localparam int PROT_LO     = 72;
  localparam int LEN_HI      = 107;
  localparam int LEN_LO      = 96;
  localparam int DISCARD_BIT = 108;

  localparam logic [2:0] CFG_TYPE_RD   = 3'b001;
  localparam logic [2:0] CFG_TYPE_WR   = 3'b010;
  localparam logic [3:0] CFG_TYPE_RESP = 4'b1011;

  localparam logic [31:0] ADDR_PASS_LO  = 32'h7000_0010;
  localparam logic [31:0] ADDR_PASS_HI  = 32'h7000_0011;
  localparam logic [31:0] ADDR_DROP_LO  = 32'h7000_0012;
  localparam logic [31:0] ADDR_DROP_HI  = 32'h7000_0013;
  localparam logic [31:0] ADDR_BYTES_LO = 32'h7000_0014;
  localparam logic [31:0] ADDR_BYTES_HI = 32'h7000_0015;
  localparam logic [31:0] ADDR_CLEAR    = 32'h7000_0018;

  typedef enum logic [1:0] {
    PKT_BYPASS  = 2'd0,
    PKT_FORWARD = 2'd1,
    PKT_DROP    = 2'd2
  } pkt_cls_e;

  // Only packets addressed to this stage can be dropped or re-stamped.
  function automatic pkt_cls_e classify(input logic [MD_W-1:0] md, input logic [7:0] lmid);
    if (md[MID_HI:MID_LO] != lmid) return PKT_BYPASS;
    if (md[DISCARD_BIT]) return PKT_DROP;
    return PKT_FORWARD;
  endfunction

endpackage

// File: rtl/fifo_1024_256.sv
// 256-entry x 1024-bit show-ahead FIFO; q presents the head word while not empty.
// Writes while full are dropped, reads while empty are ignored.
module fifo_1024_256 (
  input  logic          clock,
  input  logic          srst,
  input  logic [1023:0] data,
  input  logic          wrreq,
  input  logic          rdreq,
  output logic [1023:0] q,
  output logic          empty,
  output logic [8:0]    usedw
);
  logic [1023:0] mem_q [0:255];
  logic [7:0]    wr_ptr_q, rd_ptr_q;
  logic [8:0]    cnt_q;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == 9'd0);
  assign usedw = cnt_q;
  assign q     = mem_q[rd_ptr_q];
  assign do_wr = wrreq && (cnt_q != 9'd256);
  assign do_rd = rdreq && !empty;

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 8'd1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 8'd1;
      cnt_q <= cnt_q + 9'(do_wr) - 9'(do_rd);
    end
  end
endmodule

// File: rtl/fifo_256_256.sv
// 256-entry x 256-bit show-ahead FIFO; q presents the head word while not empty.
// Writes while full are dropped, reads while empty are ignored.
module fifo_256_256 (
  input  logic         clock,
  input  logic         srst,
  input  logic [255:0] data,
  input  logic         wrreq,
  input  logic         rdreq,
  output logic [255:0] q,
  output logic         empty,
  output logic [8:0]   usedw
);
  logic [255:0] mem_q [0:255];
  logic [7:0]   wr_ptr_q, rd_ptr_q;
  logic [8:0]   cnt_q;
  logic         do_wr, do_rd;

  assign empty = (cnt_q == 9'd0);
  assign usedw = cnt_q;
  assign q     = mem_q[rd_ptr_q];
  assign do_wr = wrreq && (cnt_q != 9'd256);
  assign do_rd = rdreq && !empty;

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 8'd1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 8'd1;
      cnt_q <= cnt_q + 9'(do_wr) - 9'(do_rd);
    end
  end
endmodule

// File: rtl/pdm_stat.sv
// Pass/drop statistics plus the configure-chain tap: counter reads are
// answered in place, the clear write is acted on, every word moves on one cycle later.
module pdm_stat
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pass_inc_i,
  input  logic             drop_inc_i,
  input  logic [11:0]      drop_len_i,
  input  logic [CFG_W-1:0] cin_data_i,
  input  logic             cin_data_wr_i,
  input  logic             cin_ready_i,
  output logic [CFG_W-1:0] cout_data_o,
  output logic             cout_data_wr_o
);
  logic [63:0]      pass_cnt_q, pass_cnt_d;
  logic [63:0]      drop_cnt_q, drop_cnt_d;
  logic [63:0]      byte_cnt_q, byte_cnt_d;
  logic [CFG_W-1:0] cout_data_q, cout_data_d;
  logic             cout_wr_q;
  logic             accept, clear, rd_hit;
  logic [2:0]       cfg_type;
  logic [31:0]      cfg_addr, rd_val;

  assign accept   = cin_data_wr_i && cin_ready_i;
  assign cfg_type = cin_data_i[126:124];
  assign cfg_addr = cin_data_i[95:64];
  assign clear    = accept && (cfg_type == CFG_TYPE_WR) && (cfg_addr == ADDR_CLEAR) && cin_data_i[0];

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    if (cfg_type == CFG_TYPE_RD) begin
      rd_hit = 1'b1;
      case (cfg_addr)
        ADDR_PASS_LO:  rd_val = pass_cnt_q[31:0];
        ADDR_PASS_HI:  rd_val = pass_cnt_q[63:32];
        ADDR_DROP_LO:  rd_val = drop_cnt_q[31:0];
        ADDR_DROP_HI:  rd_val = drop_cnt_q[63:32];
        ADDR_BYTES_LO: rd_val = byte_cnt_q[31:0];
        ADDR_BYTES_HI: rd_val = byte_cnt_q[63:32];
        default:       rd_hit = 1'b0;
      endcase
    end
    cout_data_d = cin_data_i;
    if (rd_hit) cout_data_d = {cin_data_i[133:128], CFG_TYPE_RESP, cin_data_i[123:32], rd_val};
  end

  // Clear overrides any increment landing in the same cycle.
  always_comb begin
    pass_cnt_d = pass_cnt_q + 64'(pass_inc_i);
    drop_cnt_d = drop_cnt_q + 64'(drop_inc_i);
    byte_cnt_d = drop_inc_i ? byte_cnt_q + 64'(drop_len_i) : byte_cnt_q;
    if (clear) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cout_wr_q  <= accept;
      if (accept) cout_data_q <= cout_data_d;
    end
  end

  assign cout_data_o    = cout_data_q;
  assign cout_data_wr_o = cout_wr_q;
endmodule

// File: rtl/pdm.sv
// Packet discard stage: buffers MD/PHV pairs, drops packets tagged for discard,
// re-stamps MID on local packets and passes everything else through.
module pdm
  import pdm_pkg::*;
#(
  parameter logic [7:0] LMID   = 8'd5,
  parameter logic [7:0] NMID   = 8'd6,
  parameter logic [7:0] ALF_TH = 8'd250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MD_W-1:0]   in_pdm_md,
  input  logic              in_pdm_md_wr,
  output logic              out_pdm_md_alf,
  input  logic [PHV_W-1:0]  in_pdm_phv,
  input  logic              in_pdm_phv_wr,
  output logic              out_pdm_phv_alf,
  output logic [MD_W-1:0]   out_pdm_md,
  output logic              out_pdm_md_wr,
  input  logic              in_pdm_md_alf,
  output logic [PHV_W-1:0]  out_pdm_phv,
  output logic              out_pdm_phv_wr,
  input  logic              in_pdm_phv_alf,
  input  logic [CFG_W-1:0]  cin_pdm_data,
  input  logic              cin_pdm_data_wr,
  output logic              cout_pdm_ready,
  output logic [CFG_W-1:0]  cout_pdm_data,
  output logic              cout_pdm_data_wr,
  input  logic              cin_pdm_ready
);
  logic [MD_W-1:0]  md_head, md_fwd, out_md_q;
  logic [PHV_W-1:0] phv_head, out_phv_q;
  logic             md_empty, phv_empty, pop, emit;
  logic             out_md_wr_q, out_phv_wr_q;
  logic [8:0]       md_usedw, phv_usedw;
  pkt_cls_e         cls;

  fifo_256_256 u_md_fifo (
    .clock (clk),
    .srst  (rst),
    .data  (in_pdm_md),
    .wrreq (in_pdm_md_wr),
    .rdreq (pop),
    .q     (md_head),
    .empty (md_empty),
    .usedw (md_usedw)
  );

  fifo_1024_256 u_phv_fifo (
    .clock (clk),
    .srst  (rst),
    .data  (in_pdm_phv),
    .wrreq (in_pdm_phv_wr),
    .rdreq (pop),
    .q     (phv_head),
    .empty (phv_empty),
    .usedw (phv_usedw)
  );

  assign out_pdm_md_alf  = in_pdm_md_alf  || (md_usedw  > {1'b0, ALF_TH});
  assign out_pdm_phv_alf = in_pdm_phv_alf || (phv_usedw > {1'b0, ALF_TH});

  // MD and PHV leave together, and only when the next stage can take both.
  assign pop  = !md_empty && !phv_empty && !in_pdm_md_alf && !in_pdm_phv_alf;
  assign cls  = classify(md_head, LMID);
  assign emit = pop && (cls != PKT_DROP);

  always_comb begin
    md_fwd = md_head;
    if (cls == PKT_FORWARD) md_fwd[MID_HI:MID_LO] = NMID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_md_q     <= '0;
      out_phv_q    <= '0;
      out_md_wr_q  <= 1'b0;
      out_phv_wr_q <= 1'b0;
    end else begin
      out_md_wr_q  <= emit;
      out_phv_wr_q <= emit;
      if (emit) begin
        out_md_q  <= md_fwd;
        out_phv_q <= phv_head;
      end
    end
  end

  assign out_pdm_md     = out_md_q;
  assign out_pdm_md_wr  = out_md_wr_q;
  assign out_pdm_phv    = out_phv_q;
  assign out_pdm_phv_wr = out_phv_wr_q;
  assign cout_pdm_ready = cin_pdm_ready;

  pdm_stat u_stat (
    .clk            (clk),
    .rst            (rst),
    .pass_inc_i     (emit),
    .drop_inc_i     (pop && (cls == PKT_DROP)),
    .drop_len_i     (md_head[LEN_HI:LEN_LO]),
    .cin_data_i     (cin_pdm_data),
    .cin_data_wr_i  (cin_pdm_data_wr),
    .cin_ready_i    (cin_pdm_ready),
    .cout_data_o    (cout_pdm_data),
    .cout_data_wr_o (cout_pdm_data_wr)
  );
endmodule

// File: tb/tb_pdm.sv
// Self-checking bench for pdm: scoreboard queues for the packet and configure
// outputs, a reference classifier and counter model, and directed plus random traffic.
module tb_pdm;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  in_pdm_md;
  logic          in_pdm_md_wr;
  logic          out_pdm_md_alf;
  logic [1023:0] in_pdm_phv;
  logic          in_pdm_phv_wr;
  logic          out_pdm_phv_alf;
  logic [255:0]  out_pdm_md;
  logic          out_pdm_md_wr;
  logic          in_pdm_md_alf;
  logic [1023:0] out_pdm_phv;
  logic          out_pdm_phv_wr;
  logic          in_pdm_phv_alf;
  logic [133:0]  cin_pdm_data;
  logic          cin_pdm_data_wr;
  logic          cout_pdm_ready;
  logic [133:0]  cout_pdm_data;
  logic          cout_pdm_data_wr;
  logic          cin_pdm_ready;

  always #5 clk = ~clk;

  pdm dut (
    .clk              (clk),
    .rst              (rst),
    .in_pdm_md        (in_pdm_md),
    .in_pdm_md_wr     (in_pdm_md_wr),
    .out_pdm_md_alf   (out_pdm_md_alf),
    .in_pdm_phv       (in_pdm_phv),
    .in_pdm_phv_wr    (in_pdm_phv_wr),
    .out_pdm_phv_alf  (out_pdm_phv_alf),
    .out_pdm_md       (out_pdm_md),
    .out_pdm_md_wr    (out_pdm_md_wr),
    .in_pdm_md_alf    (in_pdm_md_alf),
    .out_pdm_phv      (out_pdm_phv),
    .out_pdm_phv_wr   (out_pdm_phv_wr),
    .in_pdm_phv_alf   (in_pdm_phv_alf),
    .cin_pdm_data     (cin_pdm_data),
    .cin_pdm_data_wr  (cin_pdm_data_wr),
    .cout_pdm_ready   (cout_pdm_ready),
    .cout_pdm_data    (cout_pdm_data),
    .cout_pdm_data_wr (cout_pdm_data_wr),
    .cin_pdm_ready    (cin_pdm_ready)
  );

  int errors = 0;
  int checks = 0;
  logic [255:0]  exp_md_q[$];
  logic [1023:0] exp_phv_q[$];
  logic [133:0]  exp_cfg_q[$];
  logic [63:0]   pass_m, drop_m, byte_m;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare every output strobe against the head of its queue.
  always @(negedge clk) begin
    logic [255:0]  e_md;
    logic [1023:0] e_phv;
    logic [133:0]  e_cfg;
    if (out_pdm_md_wr || out_pdm_phv_wr) begin
      check("strobe_pair", 256'(out_pdm_phv_wr), 256'(out_pdm_md_wr));
      if (exp_md_q.size() == 0) begin
        check("unexpected_pkt", 256'(1), 256'(0));
      end else begin
        e_md  = exp_md_q.pop_front();
        e_phv = exp_phv_q.pop_front();
        check("md_out", out_pdm_md, e_md);
        for (int i = 0; i < 4; i++) check("phv_out", out_pdm_phv[i*256 +: 256], e_phv[i*256 +: 256]);
      end
    end
    if (cout_pdm_data_wr) begin
      if (exp_cfg_q.size() == 0) begin
        check("unexpected_cfg", 256'(1), 256'(0));
      end else begin
        e_cfg = exp_cfg_q.pop_front();
        check("cfg_out", 256'(cout_pdm_data), 256'(e_cfg));
      end
    end
  end

  function automatic logic [255:0] make_md(input logic [7:0] mid, input logic disc, input logic [11:0] len);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[87:80]  = mid;
    r[108]    = disc;
    r[107:96] = len;
    return r;
  endfunction

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one MD/PHV pair for a cycle and records what the stage should do with it.
  task automatic send_pkt(input logic [255:0] md);
    logic [1023:0] phv;
    logic [255:0]  e;
    phv = rand_phv();
    in_pdm_md = md;
    in_pdm_phv = phv;
    in_pdm_md_wr = 1'b1;
    in_pdm_phv_wr = 1'b1;
    @(posedge clk); #1;
    in_pdm_md_wr = 1'b0;
    in_pdm_phv_wr = 1'b0;
    if (md[87:80] == 8'd5 && md[108]) begin
      drop_m = drop_m + 64'd1;
      byte_m = byte_m + 64'(md[107:96]);
    end else begin
      e = md;
      if (md[87:80] == 8'd5) e[87:80] = 8'd6;
      exp_md_q.push_back(e);
      exp_phv_q.push_back(phv);
      pass_m = pass_m + 64'd1;
    end
  endtask

  task automatic send_cfg(input logic [133:0] w, input logic [133:0] exp_out);
    cin_pdm_data = w;
    cin_pdm_data_wr = 1'b1;
    @(posedge clk); #1;
    cin_pdm_data_wr = 1'b0;
    if (cin_pdm_ready) exp_cfg_q.push_back(exp_out);
  endtask

  function automatic logic [133:0] rand_cfg();
    return 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic cfg_read(input logic [31:0] addr, input logic [31:0] val);
    logic [133:0] w;
    w = rand_cfg();
    w[126:124] = 3'b001;
    w[95:64] = addr;
    send_cfg(w, {w[133:128], 4'b1011, w[123:32], val});
  endtask

  task automatic cfg_clear();
    logic [133:0] w;
    w = rand_cfg();
    w[126:124] = 3'b010;
    w[95:64] = 32'h7000_0018;
    w[0] = 1'b1;
    send_cfg(w, w);
    pass_m = '0;
    drop_m = '0;
    byte_m = '0;
  endtask

  task automatic read_all();
    cfg_read(32'h7000_0010, pass_m[31:0]);
    cfg_read(32'h7000_0011, pass_m[63:32]);
    cfg_read(32'h7000_0012, drop_m[31:0]);
    cfg_read(32'h7000_0013, drop_m[63:32]);
    cfg_read(32'h7000_0014, byte_m[31:0]);
    cfg_read(32'h7000_0015, byte_m[63:32]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_md_q.size() != 0 || exp_cfg_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 256'(exp_md_q.size() + exp_cfg_q.size()), 256'(0));
    exp_md_q.delete();
    exp_phv_q.delete();
    exp_cfg_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [133:0] w;
    int seen;
    int r;
    rst = 1'b1;
    in_pdm_md = '0;
    in_pdm_md_wr = 1'b0;
    in_pdm_phv = '0;
    in_pdm_phv_wr = 1'b0;
    in_pdm_md_alf = 1'b0;
    in_pdm_phv_alf = 1'b0;
    cin_pdm_data = '0;
    cin_pdm_data_wr = 1'b0;
    cin_pdm_ready = 1'b1;
    pass_m = '0;
    drop_m = '0;
    byte_m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_md_wr", 256'(out_pdm_md_wr), 256'(0));
    check("rst_phv_wr", 256'(out_pdm_phv_wr), 256'(0));
    check("rst_md", out_pdm_md, 256'(0));
    check("rst_cout_wr", 256'(cout_pdm_data_wr), 256'(0));
    check("rst_md_alf", 256'(out_pdm_md_alf), 256'(0));
    check("rst_phv_alf", 256'(out_pdm_phv_alf), 256'(0));
    realign();
    read_all();
    drain();

    // Forward: MID 5 re-stamped to 6
    send_pkt(make_md(8'd5, 1'b0, 12'($urandom_range(0, 4095))));
    drain();
    cfg_read(32'h7000_0010, 32'd1);
    drain();

    // Drop of a 64-byte packet: no strobe on either following cycle
    send_pkt(make_md(8'd5, 1'b1, 12'd64));
    @(negedge clk);
    check("drop_no_strobe0", 256'(out_pdm_md_wr), 256'(0));
    @(negedge clk);
    check("drop_no_strobe1", 256'(out_pdm_md_wr), 256'(0));
    realign();
    cfg_read(32'h7000_0012, 32'd1);
    cfg_read(32'h7000_0014, 32'd64);
    drain();

    // Bypass with foreign MID, discard bit set is ignored
    send_pkt(make_md(8'd9, 1'b1, 12'd33));
    @(negedge clk);
    check("bypass_t0", 256'(out_pdm_md_wr), 256'(0));
    @(negedge clk);
    check("bypass_t1", 256'(out_pdm_md_wr), 256'(1));
    realign();
    drain();

    // Two 100-byte drops after a clear
    cfg_clear();
    drain();
    send_pkt(make_md(8'd5, 1'b1, 12'd100));
    send_pkt(make_md(8'd5, 1'b1, 12'd100));
    drain();
    cfg_read(32'h7000_0014, 32'd200);
    cfg_read(32'h7000_0012, 32'd2);
    drain();

    // Clear lands in the same cycle as a drop increment
    send_pkt(make_md(8'd5, 1'b1, 12'd77));
    cfg_clear();
    drain();
    for (int a = 16; a < 22; a++) cfg_read(32'h7000_0000 + 32'(a), 32'd0);
    drain();

    // Backpressure: three packets held for the alf window, then back to back
    in_pdm_md_alf = 1'b1;
    for (int i = 0; i < 3; i++) send_pkt(make_md(8'd9, 1'b0, 12'd10));
    seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (out_pdm_md_wr) seen++;
    end
    check("bp_hold", 256'(seen), 256'(0));
    check("bp_alf_passthru", 256'(out_pdm_md_alf), 256'(1));
    realign();
    in_pdm_md_alf = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_burst", 256'(out_pdm_md_wr), 256'(1));
    end
    realign();
    drain();

    // Almost-full threshold: 250 entries stays low, 251 raises it
    in_pdm_phv_alf = 1'b1;
    for (int i = 0; i < 250; i++) send_pkt(make_md(8'($urandom_range(0, 9)), 1'($urandom), 12'd5));
    @(negedge clk);
    check("alf_250", 256'(out_pdm_md_alf), 256'(0));
    check("phv_alf_passthru", 256'(out_pdm_phv_alf), 256'(1));
    realign();
    send_pkt(make_md(8'd9, 1'b0, 12'd5));
    @(negedge clk);
    check("alf_251", 256'(out_pdm_md_alf), 256'(1));
    realign();
    in_pdm_phv_alf = 1'b0;
    drain();
    read_all();
    drain();

    // Random mix with gaps
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      send_pkt(make_md((r == 0) ? 8'd9 : 8'd5, 1'($urandom), 12'($urandom_range(0, 4095))));
      repeat ($urandom_range(0, 2)) realign();
    end
    drain();
    read_all();
    drain();

    // Configure words that are not counter reads pass through untouched
    w = rand_cfg(); w[126:124] = 3'b001; w[95:64] = 32'h7000_0016;
    send_cfg(w, w);
    w = rand_cfg(); w[126:124] = 3'b010; w[95:64] = 32'h7000_0018; w[0] = 1'b0;
    send_cfg(w, w);
    w = rand_cfg(); w[126:124] = 3'b011; w[95:64] = 32'h7000_0010;
    send_cfg(w, w);
    drain();
    read_all();
    drain();
    cin_pdm_ready = 1'b0;
    #1;
    check("ready_low", 256'(cout_pdm_ready), 256'(0));
    send_cfg(rand_cfg(), '0);
    @(negedge clk);
    check("no_accept", 256'(cout_pdm_data_wr), 256'(0));
    realign();
    cin_pdm_ready = 1'b1;
    #1;
    check("ready_high", 256'(cout_pdm_ready), 256'(1));
    drain();

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) send_pkt(make_md(8'd9, 1'b0, 12'd1));
    rst = 1'b1;
    void'(exp_md_q.pop_back());
    void'(exp_phv_q.pop_back());
    pass_m = '0;
    drop_m = '0;
    byte_m = '0;
    realign();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_md_wr", 256'(out_pdm_md_wr), 256'(0));
    check("midrst_phv_wr", 256'(out_pdm_phv_wr), 256'(0));
    check("midrst_md", out_pdm_md, 256'(0));
    check("midrst_phv", out_pdm_phv[255:0], 256'(0));
    check("midrst_alf", 256'(out_pdm_md_alf), 256'(0));
    realign();
    drain();
    read_all();
    drain();
    send_pkt(make_md(8'd5, 1'b0, 12'd9));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm.md
# pdm

Packet discard module, directly downstream of `scm`. It consumes the MD/PHV stream `scm` emits and removes every packet `scm` tagged for discard (MD bit 108 set, MID equal to LMID). All other packets pass through, with MID re-stamped for packets addressed to this stage. It keeps pass/drop statistics readable over the configure-packet chain.

## Interface
- `LMID`, 8'd5, local module ID; matches `scm` NMID.
- `NMID`, 8'd6, next module ID written into forwarded MD[87:80].
- `ALF_TH`, 8'd250, FIFO fill level above which almost-full is raised.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_pdm_md`  in  256  MD word from `scm`.
- `in_pdm_md_wr`  in  1  MD write strobe.
- `out_pdm_md_alf`  out  1  MD almost-full to `scm`.
- `in_pdm_phv`  in  1024  PHV word from `scm`.
- `in_pdm_phv_wr`  in  1  PHV write strobe.
- `out_pdm_phv_alf`  out  1  PHV almost-full to `scm`.
- `out_pdm_md`  out  256  MD to next stage.
- `out_pdm_md_wr`  out  1  MD valid strobe.
- `in_pdm_md_alf`  in  1  next-stage MD almost-full.
- `out_pdm_phv`  out  1024  PHV to next stage.
- `out_pdm_phv_wr`  out  1  PHV valid strobe.
- `in_pdm_phv_alf`  in  1  next-stage PHV almost-full.
- `cin_pdm_data`  in  134  configure packet word.
- `cin_pdm_data_wr`  in  1  configure word valid.
- `cout_pdm_ready`  out  1  configure ready, equal to `cin_pdm_ready` combinationally.
- `cout_pdm_data`  out  134  configure word out.
- `cout_pdm_data_wr`  out  1  configure word valid out.
- `cin_pdm_ready`  in  1  downstream configure ready.

## Operation
- **Input buffering.** MD and PHV each enter a 256-deep show-ahead FIFO.
  - `out_pdm_md_alf` = `in_pdm_md_alf` OR MD usedw > ALF_TH.
  - `out_pdm_phv_alf` = `in_pdm_phv_alf` OR PHV usedw > ALF_TH.
- **Pop rule.** `pop` = both FIFOs non-empty AND NOT `in_pdm_md_alf` AND NOT `in_pdm_phv_alf`. On a pop, both FIFOs are read together; one MD pairs with one PHV.
- **Classification of the head MD, evaluated on the pop cycle:**
  - MD[87:80]==LMID and MD[108]==1 → DROP. No output. `drop_pkt_cnt` += 1; `drop_byte_cnt` += zero-extended MD[107:96].
  - MD[87:80]==LMID and MD[108]==0 → FORWARD with MD[87:80]←NMID, other bits unchanged. `pass_pkt_cnt` += 1.
  - Otherwise → BYPASS, MD unchanged. `pass_pkt_cnt` += 1.
- **Counters.** All 64-bit; wrap modulo 2^64.
- **Configure chain.** A word is accepted only when `cin_pdm_data_wr`=1 and `cin_pdm_ready`=1. Type field is [126:124]; address is [95:64].
  - Type 3'b010 (write), address 0x70000018, data[0]=1 → clear all three counters.
  - Type 3'b001 (read), addresses 0x70000010/11 → `pass_pkt_cnt` lo/hi; 0x70000012/13 → `drop_pkt_cnt` lo/hi; 0x70000014/15 → `drop_byte_cnt` lo/hi. Response word = {[133:128], 4'b1011, [123:32], 32-bit value}.
  - Every other word is forwarded unchanged.
- **Simultaneous events.**
  - Clear and increment in the same cycle: the clear wins (counter = 0).
  - Read and increment in the same cycle: the read returns the pre-increment value.

## Timing
- Output is registered. A packet popped in cycle t appears with `out_pdm_md_wr`=`out_pdm_phv_wr`=1 in cycle t+1.
- A dropped packet produces no strobe in t+1.
- Throughput is one packet per cycle.
- Configure path has a one-cycle latency. `cout_pdm_data_wr` in t+1 equals the accepted `cin_pdm_data_wr` in t; it is 0 when no word is accepted.
- Reset clears all output registers, counters and both FIFOs to 0 / empty.
- Reset mid-stream discards any in-flight packet. The first cycle after reset deassertion issues no pop.
- Input writes while a FIFO is full are lost. Keeping the FIFO from filling is the upstream's job, enforced through the alf outputs.
- One FIFO non-empty and the other empty: no pop, wait.

## Structure
- Shared package holds:
  - MD field positions: MID [87:80], protocol [79:72], length [107:96], discard bit 108.
  - Configure type codes 3'b001 and 3'b010, and the 4'b1011 response code.
  - Counter addresses 0x70000010–0x70000018.
- One sub-module, `pdm_stat`: the three counters plus the configure read/write/forward logic.
- FIFOs reuse the existing `fifo_256_256` and `fifo_1024_256` instances, with `srst` tied to `rst`.

## Test plan
- **Forward.** MD[87:80]=5, [108]=0 → output MD[87:80]=6, all other bits equal, PHV equal; `pass_pkt_cnt`=1.
- **Drop.** MD[87:80]=5, [108]=1, [107:96]=64 → no output strobe; `drop_pkt_cnt`=1, `drop_byte_cnt`=64.
- **Bypass.** MD[87:80]=9 → output identical to input, one cycle after the pop.
- **Backpressure and alf.**
  - `in_pdm_md_alf`=1 for 10 cycles with 3 packets queued → zero pops during that window, then 3 outputs on 3 consecutive cycles.
  - 251 writes with no pops → `out_pdm_md_alf`=1.
- **Counter readback and clear.**
  - After 2 drops of 100 bytes, a read of 0x70000014 → response [127:124]=4'b1011, [31:0]=200.
  - A write to 0x70000018 with data=1 coinciding with a drop → counters read 0.
- **Reset mid-stream.** `rst` asserted during a burst → all outputs 0 the next cycle, FIFOs empty, counters 0.
